// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared types, defaults and counter-width helper for the LSTM cell-state buffer
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_HIDDEN_SIZE = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lstm_state_e;

  // Pointers must reach HIDDEN_SIZE itself, hence the extra bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cell_state_ram.sv
// rtl/cell_state_ram.sv - simple dual-port ping-pong store, synchronous write, registered read
module cell_state_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lstm_cell_state_buffer.sv
// rtl/lstm_cell_state_buffer.sv - ping-pong cell-state buffer with FIFO-style read side
// Optional sticky overflow/underflow flags are built only when CELL_BUF_ERR_EN is defined.
module lstm_cell_state_buffer
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int HIDDEN_SIZE = LSTM_HIDDEN_SIZE,
  parameter int CNT_W       = cnt_w(HIDDEN_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_start,
  input  logic                  seq_first,
  input  logic                  bilstm_done,
  input  logic                  cell_state_valid,
  input  logic [DATA_WIDTH-1:0] current_cell_state,
  input  logic                  cell_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] prev_cell_state,
  output logic                  cell_fifo_empty,
  output logic                  step_done,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] W_FULL = CNT_W'(HIDDEN_SIZE);
  localparam logic [CNT_W-1:0] W_ONE  = CNT_W'(1);

  lstm_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_rd_ptr, r_wr_ptr;
  logic r_bank_sel, r_zero_mode, r_out_zero, r_step_done;
  logic w_empty, w_start, w_pop, w_wr, w_last_wr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty   = (r_state != ST_RUN) || (r_rd_ptr == W_FULL);
  assign w_start   = step_start && !bilstm_done && (r_state != ST_RUN);
  assign w_pop     = cell_fifo_rd_en && !w_empty && !bilstm_done;
  assign w_wr      = cell_state_valid && !bilstm_done && (r_state == ST_RUN) && (r_wr_ptr < W_FULL);
  assign w_last_wr = w_wr && (r_wr_ptr == W_FULL - W_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (step_start) w_state_nxt = ST_RUN;
      ST_RUN:           if (w_last_wr)  w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
    if (bilstm_done) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || bilstm_done) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_bank_sel  <= 1'b0;
      r_zero_mode <= 1'b1;
      r_out_zero  <= 1'b1;
      r_step_done <= 1'b0;
    end else begin
      r_step_done <= w_last_wr;
      if (w_start) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_zero_mode <= seq_first || (r_state == ST_IDLE);
        // The bank just filled becomes the read bank for the new step.
        if (r_state == ST_DONE) r_bank_sel <= ~r_bank_sel;
      end else begin
        if (w_pop) begin
          r_rd_ptr   <= r_rd_ptr + W_ONE;
          r_out_zero <= r_zero_mode;
        end
        if (w_wr) r_wr_ptr <= r_wr_ptr + W_ONE;
      end
    end
  end

  cell_state_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr ({~r_bank_sel, r_wr_ptr[ADDR_W-1:0]}),
    .i_wdata (current_cell_state),
    .i_re    (w_pop),
    .i_raddr ({r_bank_sel, r_rd_ptr[ADDR_W-1:0]}),
    .o_rdata (w_rdata)
  );

  // RAM read data only moves on an accepted pop, so the output holds between pops.
  assign prev_cell_state = r_out_zero ? '0 : w_rdata;
  assign cell_fifo_empty = w_empty;
  assign step_done       = r_step_done;

`ifdef CELL_BUF_ERR_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk) begin
    if (rst || bilstm_done) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (cell_state_valid && ((r_state != ST_RUN) || (r_wr_ptr == W_FULL))) r_overflow <= 1'b1;
      if (cell_fifo_rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_lstm_cell_state_buffer.sv
// tb/tb_lstm_cell_state_buffer.sv - scoreboard bench with a vector-level reference model (honours CELL_BUF_ERR_EN)
module tb_lstm_cell_state_buffer;

  localparam int DW = 16;
  localparam int H  = 64;

  logic          clk = 1'b0;
  logic          rst, step_start, seq_first, bilstm_done;
  logic          cell_state_valid, cell_fifo_rd_en;
  logic [DW-1:0] current_cell_state;
  logic [DW-1:0] prev_cell_state;
  logic          cell_fifo_empty, step_done, overflow, underflow;

  lstm_cell_state_buffer #(.DATA_WIDTH(DW), .HIDDEN_SIZE(H)) dut (
    .clk                (clk),
    .rst                (rst),
    .step_start         (step_start),
    .seq_first          (seq_first),
    .bilstm_done        (bilstm_done),
    .cell_state_valid   (cell_state_valid),
    .current_cell_state (current_cell_state),
    .cell_fifo_rd_en    (cell_fifo_rd_en),
    .prev_cell_state    (prev_cell_state),
    .cell_fifo_empty    (cell_fifo_empty),
    .step_done          (step_done),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole vectors, not banks or pointers.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_serve[$];
  logic [DW-1:0] m_new[$];
  logic [DW-1:0] m_done_vec[$];
  bit            m_run  = 0;
  bit            m_idle = 1;
  int            m_rd   = 0;
  bit            m_ovf  = 0;
  bit            m_unf  = 0;
  logic [DW-1:0] m_last = '0;

  function automatic void model_clear();
    m_run = 0; m_idle = 1; m_rd = 0; m_ovf = 0; m_unf = 0; m_last = '0;
    m_new.delete(); m_serve.delete();
  endfunction

  task automatic cyc(input bit r, input bit st, input bit sf, input bit bd,
                     input bit wv, input logic [DW-1:0] wd, input bit rd);
    bit exp_done;
    rst = r; step_start = st; seq_first = sf; bilstm_done = bd;
    cell_state_valid = wv; current_cell_state = wd; cell_fifo_rd_en = rd;
    if (!r) chk("empty", 32'(cell_fifo_empty), 32'(!(m_run && m_rd < H)));
    exp_done = 0;
    if (r || bd) begin
      model_clear();
    end else begin
      if (wv && !m_run) m_ovf = 1;
      if (rd && !(m_run && m_rd < H)) m_unf = 1;
      if (st && !m_run) begin
        m_serve.delete();
        if (m_idle || sf) for (int i = 0; i < H; i++) m_serve.push_back('0);
        else m_serve = m_done_vec;
        m_new.delete(); m_rd = 0; m_run = 1; m_idle = 0;
      end else if (m_run) begin
        if (rd && m_rd < H) begin
          exp_q.push_back(m_serve[m_rd]);
          m_last = m_serve[m_rd];
          m_rd++;
        end
        if (wv) begin
          m_new.push_back(wd);
          if (m_new.size() == H) begin
            exp_done = 1; m_run = 0; m_done_vec = m_new;
          end
        end
      end
    end
    @(posedge clk); #1;
    chk("step_done", 32'(step_done), 32'(exp_done));
`ifdef CELL_BUF_ERR_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`else
    chk("overflow", 32'(overflow), 32'd0);
    chk("underflow", 32'(underflow), 32'd0);
`endif
  endtask

  // Monitor: every accepted pop yields one registered element, checked a half cycle later.
  bit pop_seen = 0;
  always @(posedge clk)
    pop_seen <= cell_fifo_rd_en && !cell_fifo_empty && !rst && !bilstm_done;

  always @(negedge clk) begin
    if (pop_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no element", prev_cell_state);
      end else begin
        chk("prev_cell_state", 32'(prev_cell_state), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic rand_step(input bit sf);
    cyc(0, 1, sf, 0, 0, '0, 0);
    for (int k = 0; k < 2000 && m_run; k++)
      cyc(0, $urandom_range(0, 7) == 0, 0, 0, $urandom_range(0, 1) == 1,
          DW'($urandom), $urandom_range(0, 1) == 1);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, 0, $urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) == 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, 0, '0, 0);
    chk("reset_prev", 32'(prev_cell_state), 32'd0);
    chk("reset_empty", 32'(cell_fifo_empty), 32'd1);

    // First step: zeros served, then 0..63 written.
    cyc(0, 1, 1, 0, 0, '0, 0);
    for (int i = 0; i < H; i++) cyc(0, 0, 0, 0, 0, '0, 1);
    chk("empty_after_64", 32'(cell_fifo_empty), 32'd1);
    for (int i = 0; i < H; i++) cyc(0, 0, 0, 0, 1, DW'(i), 0);
    idle(2);

    // Second step: read 0..63 back while writing 100+i.
    cyc(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < H; i++) cyc(0, 0, 0, 0, 1, DW'(100 + i), 1);
    // Extra pop while empty must not disturb the held output.
    cyc(0, 0, 0, 0, 0, '0, 1);
    chk("prev_hold", 32'(prev_cell_state), 32'(m_last));
    // A 65th write is illegal and must not be stored.
    cyc(0, 0, 0, 0, 1, 16'hdead, 0);
    idle(1);

    cyc(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < H; i++) cyc(0, 0, 0, 0, 1, DW'(16'h8000 + i), 1);
    idle(1);

    for (int s = 0; s < 4; s++) rand_step($urandom_range(0, 4) == 0);

    // Clear flags; simultaneous start and done stays idle.
    cyc(0, 0, 0, 1, 0, '0, 0);
    cyc(0, 1, 0, 1, 0, '0, 0);
    chk("flags_cleared", 32'({overflow, underflow}), 32'd0);
    idle(1);

    // Reset mid-step forces zero mode on the following step.
    cyc(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, DW'(16'h1234 + i), 0);
    cyc(1, 0, 0, 0, 0, '0, 0);
    cyc(0, 1, 0, 0, 0, '0, 0);
    for (int i = 0; i < H; i++) cyc(0, 0, 0, 0, 1, DW'($urandom), 1);
    for (int s = 0; s < 2; s++) rand_step(0);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
